darkroom_spi_receiver: RTL and testbench

SPI slave deserializer on the far end of the darkroom sensor link: recovers 32-bit lighthouse sensor words shifted out on mosi/sck/ss_n and hands them to the consumer through a buffered valid/ready stream. All three SPI pins are asynchronous to the local clock and are oversampled. Each word is decoded into lighthouse, axis, valid, sensor id and sweep duration fields. Per-frame integrity and overflow are tracked with saturating counters.

---
 rtl/darkroom_pkg.sv | 38 +++
 rtl/darkroom_rx_fifo.sv | 72 +++++++
 rtl/darkroom_spi_receiver.sv | 191 +++++++++++++++++++
 tb/tb_darkroom_spi_receiver.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/darkroom_pkg.sv
// Shared definitions for the darkroom sensor link: word size, field layout
// of a lighthouse sensor word and small helpers used by both link ends.
package darkroom_pkg;

  localparam int WORD_BITS = 32;

  // Field positions inside a 32-bit sensor word
  localparam int LH_BIT    = 31;
  localparam int AXIS_BIT  = 30;
  localparam int VALID_BIT = 29;
  localparam int ID_MSB    = 28;
  localparam int ID_LSB    = 20;
  localparam int DUR_MSB   = 19;
  localparam int DUR_LSB   = 0;

  localparam int ID_BITS  = ID_MSB - ID_LSB + 1;
  localparam int DUR_BITS = DUR_MSB - DUR_LSB + 1;

  // Packed view of a sensor word; member order matches the bit layout above
  typedef struct packed {
    logic                lighthouse;
    logic                axis;
    logic                valid;
    logic [ID_BITS-1:0]  sensor_id;
    logic [DUR_BITS-1:0] duration;
  } sensor_word_t;

  // Reinterpret a raw word as its decoded fields
  function automatic sensor_word_t decode_word(input logic [WORD_BITS-1:0] raw);
    return sensor_word_t'(raw);
  endfunction

  // 16-bit increment that sticks at all-ones
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/darkroom_rx_fifo.sv
// Synchronous FIFO for received sensor words. The head entry is read straight
// from the storage registers; a push into a full FIFO is accepted only when a
// pop happens in the same cycle.
module darkroom_rx_fifo
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // A pop frees the head slot this cycle, so a push into a full FIFO can land
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  // Storage write
  // NOTE: the storage array has no reset; only pointers and count are reset,
  // and the head output is forced to zero while empty, so stale contents are
  // never visible.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy count
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_data = empty ? '0 : mem[rd_ptr];
  assign level     = count;

endmodule

// File: rtl/darkroom_spi_receiver.sv
// SPI mode-0 slave deserializer for the darkroom sensor link. Oversamples
// sck/ss_n/mosi, assembles 32-bit words MSB first, buffers them in a FIFO and
// presents the head word with its decoded fields on a valid/ready stream.
module darkroom_spi_receiver
  import darkroom_pkg::*;
#(
  parameter int WORD_BITS   = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sck_i,
  input  logic                          ss_n_i,
  input  logic                          mosi_i,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WORD_BITS-1:0]          word_o,
  output logic                          lighthouse_o,
  output logic                          axis_o,
  output logic                          valid_o,
  output logic [8:0]                    sensor_id_o,
  output logic [19:0]                   duration_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   overflow_cnt,
  output logic [15:0]                   partial_cnt,
  output logic                          busy
);

  localparam int CNT_W = $clog2(WORD_BITS);

  localparam logic [1:0] ST_ARMED     = 2'd0;
  localparam logic [1:0] ST_SHIFT     = 2'd1;
  localparam logic [1:0] ST_WAIT_IDLE = 2'd2;

  // Synchronizer chains and edge history
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ss_n_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_hist;
  logic                   ss_n_hist;

  logic sck_s;
  logic ss_n_s;
  logic mosi_s;
  logic sck_rise;
  logic ss_n_fall;
  logic ss_n_rise;

  // Receiver state
  logic [1:0]           state;
  logic                 post_reset;
  logic [CNT_W-1:0]     bit_cnt;
  logic [CNT_W-1:0]     bit_cnt_next;
  logic                 word_done;
  logic [WORD_BITS-1:0] shift_reg;
  logic                 push_pending;

  // FIFO interface
  logic                            pop;
  logic                            drop;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic [WORD_BITS-1:0]            head_word;
  sensor_word_t                    head_fields;

  // Synchronize the SPI pins; left unreset so the true pin level is already
  // settled when reset releases and no false edge is reported
  always_ff @(posedge clk) begin
    sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck_i};
    ss_n_sync <= {ss_n_sync[SYNC_STAGES-2:0], ss_n_i};
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
    sck_hist  <= sck_sync[SYNC_STAGES-1];
    ss_n_hist <= ss_n_sync[SYNC_STAGES-1];
  end

  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign ss_n_s    = ss_n_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_hist;
  assign ss_n_fall = ~ss_n_s & ss_n_hist;
  assign ss_n_rise = ss_n_s & ~ss_n_hist;

  // Bit counter advance for the current sck edge, flagging word completion
  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    bit_cnt_next = bit_cnt;
    word_done    = 1'b0;
    if (sck_rise) begin
      if (bit_cnt == CNT_W'(WORD_BITS - 1)) begin
        bit_cnt_next = '0;
        word_done    = 1'b1;
      end else begin
        bit_cnt_next = bit_cnt + CNT_W'(1);
      end
    end
  end

  // Frame FSM: shift register, bit counter, push request and partial count
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_ARMED;
      post_reset   <= 1'b1;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      push_pending <= 1'b0;
      partial_cnt  <= '0;
    end else begin
      post_reset   <= 1'b0;
      push_pending <= 1'b0;
      case (state)
        ST_ARMED: begin
          // Coming out of reset inside a frame: wait for it to end rather
          // than start assembling from a misaligned bit
          if (post_reset && !ss_n_s && !ss_n_fall) begin
            state <= ST_WAIT_IDLE;
          end else if (ss_n_fall) begin
            state     <= ST_SHIFT;
            bit_cnt   <= '0;
            shift_reg <= '0;
          end
        end
        ST_SHIFT: begin
          if (sck_rise) begin
            shift_reg    <= {shift_reg[WORD_BITS-2:0], mosi_s};
            bit_cnt      <= bit_cnt_next;
            push_pending <= word_done;
          end
          // A coincident sck edge is already folded into bit_cnt_next
          if (ss_n_rise) begin
            state <= ST_ARMED;
            if (bit_cnt_next != '0) begin
              partial_cnt <= sat_inc16(partial_cnt);
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (ss_n_s) begin
            state <= ST_ARMED;
          end
        end
        default: begin
          state <= ST_ARMED;
        end
      endcase
    end
  end

  assign busy = (state == ST_SHIFT);

  // A completed word is pushed the cycle after its last bit; the shift
  // register cannot change again before then because sck is at most clk/8
  assign pop  = out_valid & out_ready;
  assign drop = push_pending & fifo_full & ~pop;

  // Count words lost to a full FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_cnt <= '0;
    end else if (drop) begin
      overflow_cnt <= sat_inc16(overflow_cnt);
    end
  end

  darkroom_rx_fifo #(
    .WIDTH (WORD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_pending),
    .push_data (shift_reg),
    .pop       (pop),
    .head_data (head_word),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid   = ~fifo_empty;
  assign word_o      = head_word;
  assign head_fields = decode_word(head_word);

  assign lighthouse_o = head_fields.lighthouse;
  assign axis_o       = head_fields.axis;
  assign valid_o      = head_fields.valid;
  assign sensor_id_o  = head_fields.sensor_id;
  assign duration_o   = head_fields.duration;

endmodule

// File: tb/tb_darkroom_spi_receiver.sv
// Self-checking bench for darkroom_spi_receiver: directed SPI frames drive the
// DUT, expected words go into a scoreboard queue, and a monitor compares each
// word the DUT hands over against the queue head.
module tb_darkroom_spi_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic        sck_i;
  logic        ss_n_i;
  logic        mosi_i;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] word_o;
  logic        lighthouse_o;
  logic        axis_o;
  logic        valid_o;
  logic [8:0]  sensor_id_o;
  logic [19:0] duration_o;
  logic [4:0]  fifo_level;
  logic [15:0] overflow_cnt;
  logic [15:0] partial_cnt;
  logic        busy;

  logic [31:0] exp_q [$];
  logic [31:0] exp_w;
  int          check_cnt = 0;
  int          fail_cnt  = 0;
  int          lat;

  always #5 clk = ~clk;

  darkroom_spi_receiver #(
    .WORD_BITS   (32),
    .FIFO_DEPTH  (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sck_i        (sck_i),
    .ss_n_i       (ss_n_i),
    .mosi_i       (mosi_i),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .word_o       (word_o),
    .lighthouse_o (lighthouse_o),
    .axis_o       (axis_o),
    .valid_o      (valid_o),
    .sensor_id_o  (sensor_id_o),
    .duration_o   (duration_o),
    .fifo_level   (fifo_level),
    .overflow_cnt (overflow_cnt),
    .partial_cnt  (partial_cnt),
    .busy         (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    check_cnt++;
    if (act !== req) begin
      fail_cnt++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every accepted head word must match the scoreboard head
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_cnt++;
        fail_cnt++;
        $display("FAIL unexpected_word actual=0x%0h required=none", word_o);
      end else begin
        exp_w = exp_q.pop_front();
        check("word", word_o, exp_w);
        check("lighthouse", 32'(lighthouse_o), 32'(exp_w[31]));
        check("axis", 32'(axis_o), 32'(exp_w[30]));
        check("valid", 32'(valid_o), 32'(exp_w[29]));
        check("sensor_id", 32'(sensor_id_o), 32'(exp_w[28:20]));
        check("duration", 32'(duration_o), 32'(exp_w[19:0]));
      end
    end
  end

  // Inputs change 2 ns after a rising clk; all later delays are multiples of
  // the clk period so that phase is kept
  task automatic align();
    @(posedge clk);
    #2;
  endtask

  task automatic frame_begin();
    align();
    ss_n_i = 1'b0;
    #40;
  endtask

  // Send the top n bits of w, MSB first, sck = clk/8
  task automatic send_bits(input logic [31:0] w, input int n);
    for (int j = 0; j < n; j++) begin
      mosi_i = w[31-j];
      #40 sck_i = 1'b1;
      #40 sck_i = 1'b0;
    end
  endtask

  task automatic frame_end();
    #40 ss_n_i = 1'b1;
    repeat (10) @(posedge clk);
    #2;
  endtask

  task automatic send_word_frame(input logic [31:0] w);
    frame_begin();
    exp_q.push_back(w);
    send_bits(w, 32);
    frame_end();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    check("drain_left", 32'(exp_q.size()), 32'd0);
    check("drain_level", 32'(fifo_level), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w;
    reset     = 1'b1;
    sck_i     = 1'b0;
    ss_n_i    = 1'b1;
    mosi_i    = 1'b0;
    out_ready = 1'b0;
    repeat (6) @(posedge clk);
    #2 reset = 1'b0;
    align();

    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_overflow", 32'(overflow_cnt), 32'd0);
    check("rst_partial", 32'(partial_cnt), 32'd0);
    check("rst_word", word_o, 32'd0);

    // Single word, decoded fields and end-to-end latency
    frame_begin();
    w = 32'hA0A12345;
    exp_q.push_back(w);
    send_bits(w, 31);
    check("busy_in_frame", 32'(busy), 32'd1);
    mosi_i = w[0];
    #40 sck_i = 1'b1;
    lat = 0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    check("latency_valid", 32'(out_valid), 32'd1);
    check("latency_le_5", 32'(lat >= 1 && lat <= 5), 32'd1);
    check("t1_lighthouse", 32'(lighthouse_o), 32'd1);
    check("t1_axis", 32'(axis_o), 32'd0);
    check("t1_valid", 32'(valid_o), 32'd1);
    check("t1_sensor_id", 32'(sensor_id_o), 32'h00A);
    check("t1_duration", 32'(duration_o), 32'h12345);
    sck_i = 1'b0;
    frame_end();
    check("busy_after_frame", 32'(busy), 32'd0);
    drain();
    out_ready = 1'b0;

    // Four words in one frame, held, then drained in order
    frame_begin();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: w = 32'h11111111;
        1: w = 32'h80000001;
        2: w = 32'hDEADBEEF;
        default: w = 32'h7FFFFFFF;
      endcase
      exp_q.push_back(w);
      send_bits(w, 32);
    end
    frame_end();
    check("t2_level", 32'(fifo_level), 32'd4);
    check("t2_head_stable", word_o, 32'h11111111);
    drain();
    out_ready = 1'b0;

    // Twenty words into a 16-deep FIFO: four dropped, first sixteen kept
    frame_begin();
    for (int i = 0; i < 20; i++) begin
      w = 32'h5A000000 | (32'(i) << 8) | 32'(i);
      if (i < 16) exp_q.push_back(w);
      send_bits(w, 32);
    end
    frame_end();
    check("t3_level", 32'(fifo_level), 32'd16);
    check("t3_overflow", 32'(overflow_cnt), 32'd4);
    check("t3_head", word_o, 32'h5A000000);
    drain();
    check("t3_overflow_kept", 32'(overflow_cnt), 32'd4);

    // Frame ending after 17 bits, then a full word
    out_ready = 1'b1;
    frame_begin();
    send_bits(32'hFFFF8000, 17);
    frame_end();
    check("t4_partial", 32'(partial_cnt), 32'd1);
    check("t4_level", 32'(fifo_level), 32'd0);
    send_word_frame(32'h12345678);
    drain();
    check("t4_partial_kept", 32'(partial_cnt), 32'd1);

    // Reset at bit 10 with ss_n still low
    out_ready = 1'b0;
    send_word_frame(32'h0F0F0F0F);
    check("t5_level_before", 32'(fifo_level), 32'd1);
    frame_begin();
    send_bits(32'hAAAAAAAA, 10);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    exp_q.delete();
    align();
    check("t5_level", 32'(fifo_level), 32'd0);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_word", word_o, 32'd0);
    check("t5_overflow", 32'(overflow_cnt), 32'd0);
    check("t5_partial", 32'(partial_cnt), 32'd0);
    send_bits(32'h55555555, 22);
    check("t5_busy_ignored", 32'(busy), 32'd0);
    check("t5_level_ignored", 32'(fifo_level), 32'd0);
    frame_end();
    check("t5_partial_after", 32'(partial_cnt), 32'd0);
    check("t5_level_after", 32'(fifo_level), 32'd0);
    out_ready = 1'b1;
    send_word_frame(32'hCAFEF00D);
    drain();

    // Push and pop in the same clk with the FIFO full
    out_ready = 1'b0;
    frame_begin();
    for (int i = 0; i < 16; i++) begin
      w = 32'h3C000000 | 32'(i);
      exp_q.push_back(w);
      send_bits(w, 32);
    end
    w = 32'hF00D0017;
    exp_q.push_back(w);
    send_bits(w, 31);
    mosi_i = w[0];
    #40 sck_i = 1'b1;
    // Raw edge -> 2 sync flops -> detect -> push request: the push lands on
    // the 4th rising clk after the raw edge, so ready is high exactly there
    repeat (3) @(posedge clk);
    #2 out_ready = 1'b1;
    @(posedge clk);
    #2 out_ready = 1'b0;
    check("t6_level", 32'(fifo_level), 32'd16);
    check("t6_overflow", 32'(overflow_cnt), 32'd0);
    sck_i = 1'b0;
    frame_end();
    check("t6_level_after", 32'(fifo_level), 32'd16);
    check("t6_overflow_after", 32'(overflow_cnt), 32'd0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
    $finish;
  end

endmodule
